// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU / load) round-robin writeback arbiter feeding the register-file
// write port, plus a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int LD_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_rd,
  output logic [31:0] busy,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3
);

  localparam int DATA_W = 32;

  logic              ptr_ld;
  logic              grant;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              wr_vld_p1;
  logic [4:0]        a3_p1;
  logic [DATA_W-1:0] wd3_p1;
  logic [31:0]       busy_q;

  // Clear first so that a reserve landing on the same edge wins; x0 is never busy.
  function automatic logic [31:0] busy_next(input logic [31:0] cur,
                                            input logic        clr_en,
                                            input logic [4:0]  clr_rd,
                                            input logic        set_en,
                                            input logic [4:0]  set_rd);
    logic [31:0] nxt;
    nxt = cur;
    if (clr_en) nxt[clr_rd] = 1'b0;
    if (set_en && (set_rd != 5'd0)) nxt[set_rd] = 1'b1;
    nxt[0] = 1'b0;
    return nxt;
  endfunction

  always_comb begin
    alu_ready = !rst && alu_valid && (!ld_valid || !ptr_ld);
    ld_ready  = !rst && ld_valid && (!alu_valid || ptr_ld);
    grant     = alu_ready || ld_ready;
    sel_rd    = ld_ready ? ld_rd : alu_rd;
    sel_data  = ld_ready ? ld_data : alu_data;
  end

  // Stage p0 -> p1: handshake captured into the single registered write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_ld    <= (LD_FIRST != 0);
      wr_vld_p1 <= 1'b0;
      a3_p1     <= '0;
      wd3_p1    <= '0;
      busy_q    <= '0;
    end else begin
      if (alu_ready)     ptr_ld <= 1'b1;
      else if (ld_ready) ptr_ld <= 1'b0;
      wr_vld_p1 <= grant && (sel_rd != 5'd0);
      if (grant) begin
        a3_p1  <= sel_rd;
        wd3_p1 <= sel_data;
      end
      busy_q <= busy_next(busy_q, wr_vld_p1, a3_p1, rsv_en, rsv_rd);
    end
  end

  assign WE3  = wr_vld_p1;
  assign A3   = a3_p1;
  assign WD3  = wd3_p1;
  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a driver pushes expected grants and
// next-cycle writeback/busy state into queues, a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  localparam int LD_FIRST = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, rsv_en = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0, rsv_rd = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3, busy;

  regfile_wb_arbiter #(.LD_FIRST(LD_FIRST)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd), .busy(busy),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file x0 as a real register: only the arbiter keeps it clean.
  logic [31:0] rf0 = '0;
  always @(posedge clk) if (WE3 === 1'b1 && A3 == 5'd0) rf0 <= WD3;

  typedef struct { int cyc; logic a; logic l; } rdy_t;
  typedef struct { int cyc; logic we; logic [4:0] a3; logic [31:0] wd; logic [31:0] bz; } out_t;
  rdy_t rq[$];
  out_t oq[$];

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_prio_ld;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_pend[32];
  bit          m_ga, m_gl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One cycle of stimulus; the reference model decides grants and the next visible state.
  task automatic drive(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                       input logic re, input logic [4:0] rr);
    bit ga, gl;
    @(posedge clk); #1;
    rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd; rsv_en = re; rsv_rd = rr;
    if (r) begin
      ga = 0; gl = 0;
    end else if (av && lv) begin
      ga = !m_prio_ld; gl = m_prio_ld;
    end else begin
      ga = av; gl = lv;
    end
    rq.push_back('{cyc, ga, gl});
    if (r) begin
      m_we = 0; m_a3 = '0; m_wd = '0; m_prio_ld = (LD_FIRST != 0);
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else begin
      if (m_we) m_pend[m_a3] = 0;
      if (re && rr != 5'd0) m_pend[rr] = 1;
      if (ga || gl) begin
        m_a3 = ga ? ar : lr;
        m_wd = ga ? ad : ldd;
        m_we = (m_a3 != 5'd0);
        m_prio_ld = ga;
      end else begin
        m_we = 0;
      end
    end
    oq.push_back('{cyc + 1, m_we, m_a3, m_wd, pend_vec()});
    m_ga = ga; m_gl = gl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  always @(negedge clk) begin : monitor
    rdy_t r;
    out_t o;
    while (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      chk("alu_ready", 32'(alu_ready), 32'(r.a));
      chk("ld_ready", 32'(ld_ready), 32'(r.l));
    end
    while (oq.size() > 0 && oq[0].cyc <= cyc) begin
      o = oq.pop_front();
      chk("WE3", 32'(WE3), 32'(o.we));
      chk("A3", 32'(A3), 32'(o.a3));
      chk("WD3", WD3, o.wd);
      chk("busy", busy, o.bz);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ap, lp;
    logic [4:0]  ard, lrd;
    logic [31:0] adat, ldat;

    // Reset state
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    drive(1'b1, 1'b1, 5'd4, 32'd1, 1'b1, 5'd6, 32'd2, 1'b0, 5'd0);
    #2 chk("rst_ready", 32'({alu_ready, ld_ready}), 32'd0);
    idle();
    #2 chk("rst_we3", 32'(WE3), 32'd0);
    chk("rst_a3", 32'(A3), 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_busy", busy, 32'd0);

    // Single grant
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #2 chk("single_rdy", 32'(alu_ready), 32'd1);
    idle();
    #2 chk("single_we3", 32'(WE3), 32'd1);
    chk("single_a3", 32'(A3), 32'd5);
    chk("single_wd3", WD3, 32'hDEADBEEF);

    // Contention from reset: ALU, LD, ALU, LD
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'(20 + i), 32'(200 + i), 1'b0, 5'd0);
      #2 chk("cont_alu", 32'(alu_ready), 32'(i % 2 == 0));
      chk("cont_ld", 32'(ld_ready), 32'(i % 2 == 1));
      if (i > 0) chk("cont_a3", 32'(A3), ((i - 1) % 2 == 0) ? 32'(10 + i - 1) : 32'(20 + i - 1));
    end
    idle();
    #2 chk("cont_a3_last", 32'(A3), 32'd23);

    // x0 suppression
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    #2 chk("x0_rdy", 32'(ld_ready), 32'd1);
    idle();
    #2 chk("x0_we3", 32'(WE3), 32'd0);
    idle();
    #2 chk("x0_read", rf0, 32'd0);

    // Scoreboard set / clear / set-wins
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    idle();
    #2 chk("sb_set", 32'(busy[7]), 32'd1);
    drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    #2 chk("sb_we3", 32'(WE3), 32'd1);
    chk("sb_still", 32'(busy[7]), 32'd1);
    idle();
    #2 chk("sb_clr", 32'(busy[7]), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    drive(1'b0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    idle();
    #2 chk("sb_setwins", 32'(busy[7]), 32'd1);

    // Reset mid-operation discards the pending write
    drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    #2 chk("rmid_we3", 32'(WE3), 32'd0);
    chk("rmid_busy", busy, 32'd0);
    drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
    #2 chk("rmid_ptr", 32'(alu_ready), 32'(LD_FIRST == 0));
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);

    // Idle bus holds A3/WD3 and the pointer
    drive(1'b0, 1'b1, 5'd3, 32'hA5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      idle();
      #2 chk("idle_we3", 32'(WE3), 32'd0);
      chk("idle_a3", 32'(A3), 32'd3);
      chk("idle_wd3", WD3, 32'hA5A5);
    end
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
    #2 chk("idle_ptr", 32'(ld_ready), 32'd1);
    chk("idle_ptr_alu", 32'(alu_ready), 32'd0);

    // Randomized traffic; requesters hold their request until handshake
    ap = 1; ard = 5'd4; adat = 32'h44; lp = 0; lrd = '0; ldat = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1;
        ard = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        adat = $urandom;
      end
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1;
        lrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        ldat = $urandom;
      end
      drive(($urandom_range(0, 59) == 0), ap, ard, adat, lp, lrd, ldat,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      if (m_ga) ap = 0;
      if (m_gl) lp = 0;
    end

    idle();
    @(posedge clk);
    @(negedge clk);
    #1 chk("drain_rq", 32'(rq.size()), 32'd0);
    chk("drain_oq", 32'(oq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter LD_FIRST, default 0, which sets the initial round-robin priority (0 = ALU first, 1 = load first).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port alu_valid, input, 1 bit: ALU writeback request.
REQ-005 The block SHALL have port alu_rd, input, 5 bits: ALU destination register.
REQ-006 The block SHALL have port alu_data, input, 32 bits: ALU result.
REQ-007 The block SHALL have port alu_ready, output, 1 bit: ALU request granted this cycle.
REQ-008 The block SHALL have ports ld_valid (input, 1 bit), ld_rd (input, 5 bits), ld_data (input, 32 bits) and ld_ready (output, 1 bit), with the same meanings for the load-unit requester.
REQ-009 The block SHALL have port rsv_en, input, 1 bit: decode reserves a destination register.
REQ-010 The block SHALL have port rsv_rd, input, 5 bits: the register being reserved.
REQ-011 The block SHALL have port busy, output, 32 bits: scoreboard; bit i set means register i has a pending write.
REQ-012 The block SHALL have ports WE3 (output, 1 bit), A3 (output, 5 bits) and WD3 (output, 32 bits), which drive the register-file write port.

Function
REQ-013 A handshake SHALL occur on a requester when its valid and ready are both high in the same cycle.
REQ-014 ready SHALL be combinational from the valid inputs and the priority pointer, and SHALL never be high while the matching valid is low.
REQ-015 At most one ready SHALL be high per cycle.
REQ-016 When only one valid is high, that requester SHALL be granted regardless of the pointer.
REQ-017 When both valids are high, the requester named by the pointer SHALL be granted.
REQ-018 After every grant, the pointer SHALL name the non-granted requester at the next edge; with no grant, the pointer SHALL hold.
REQ-019 A requester SHALL keep valid, rd and data stable until its handshake; the block SHALL NOT buffer more than the one registered write.
REQ-020 A handshake in cycle N SHALL drive WE3=1, A3=rd and WD3=data during cycle N+1, so the register file captures the write at the edge ending cycle N+1 (latency 1).
REQ-021 A handshake with rd=0 SHALL be accepted normally (ready high) but SHALL produce WE3=0 in cycle N+1.
REQ-022 With no handshake in cycle N, WE3 SHALL be 0 in cycle N+1; A3 and WD3 SHALL hold their last values.
REQ-023 rsv_en=1 with rsv_rd!=0 SHALL set busy[rsv_rd] at the next edge.
REQ-024 A cycle with WE3=1 SHALL clear busy[A3] at the edge ending that cycle.
REQ-025 If a set and a clear target the same bit at the same edge, the set SHALL win.
REQ-026 busy[0] SHALL always read 0.
REQ-027 Clearing a bit that is not set SHALL be harmless.
REQ-028 The block SHALL take no reservation-count overflow action: a second reserve of an already busy register leaves the bit at 1, and the first write clears it.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set WE3=0, A3=0, WD3=0, busy=0 and pointer=LD_FIRST.
REQ-030 While rst=1, alu_ready and ld_ready SHALL be 0 and no handshake SHALL occur.
REQ-031 Reset asserted in the cycle after a handshake SHALL discard the pending write (WE3=0 after the reset edge) and SHALL clear busy.

Verification
REQ-032 The bench SHALL cover single grant: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, ld_valid=0 -> alu_ready=1 in the same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-033 The bench SHALL cover contention: both valid for 4 cycles with LD_FIRST=0 after reset -> grants in the order ALU, LD, ALU, LD; writes appear one cycle later in the same order.
REQ-034 The bench SHALL cover x0 suppression: ld_valid=1, ld_rd=0, ld_data=0x1234 -> ld_ready=1; next cycle WE3=0; a register-file read of x0 stays 0.
REQ-035 The bench SHALL cover the scoreboard: rsv_en with rsv_rd=7 -> busy[7]=1 next cycle; ALU write to rd=7 -> busy[7] clears at the edge ending its WE3 cycle; a reserve of 7 at that same edge keeps busy[7]=1.
REQ-036 The bench SHALL cover reset mid-operation: handshake with rd=9 in cycle N, rst=1 in cycle N+1 -> WE3=0 and busy=0 after the reset edge, and the pointer returns to LD_FIRST.
REQ-037 The bench SHALL cover an idle bus: no valids for 3 cycles -> WE3=0 throughout, A3 and WD3 unchanged, and the pointer unchanged.
